// File: rtl/game_pkg.sv
// Shared constants for the game sequencer: FSM state codes, jump phases, default timing.
package game_pkg;

    // Sequencer states (3-bit, legacy encoding)
    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_BG     = 3'd2;
    localparam logic [2:0] S_BG_ACK = 3'd3;
    localparam logic [2:0] S_MOVE   = 3'd4;
    localparam logic [2:0] S_CH     = 3'd5;
    localparam logic [2:0] S_CH_ACK = 3'd6;

    // Jump physics phases (2-bit)
    localparam logic [1:0] P_GROUND = 2'd0;
    localparam logic [1:0] P_RISE   = 2'd1;
    localparam logic [1:0] P_FALL   = 2'd2;

    // 50 MHz clock / 60 Hz frame rate
    localparam int unsigned FRAME_DIV_DEFAULT   = 833333;
    localparam int unsigned JUMP_HEIGHT_DEFAULT = 24;

endpackage

// File: rtl/frame_rate_divider.sv
// Frame pacing: divides clk down to a one-cycle tick every FRAME_DIV cycles.
module frame_rate_divider
    import game_pkg::*;
#(
    parameter int unsigned FRAME_DIV = FRAME_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(FRAME_DIV);

    logic [DIV_W-1:0] divCount;

    // Count 0..FRAME_DIV-1, wrap to 0 and pulse tick once per wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCount <= '0;
            tick     <= 1'b0;
        end else if (divCount == DIV_W'(FRAME_DIV - 1)) begin
            divCount <= '0;
            tick     <= 1'b1;
        end else begin
            divCount <= divCount + DIV_W'(1);
            tick     <= 1'b0;
        end
    end

endmodule

// File: rtl/mush_jump_control.sv
// Per-frame render sequencer: scroll, background sweep, character move/sweep, and jump physics.
module mush_jump_control
    import game_pkg::*;
#(
    parameter int unsigned FRAME_DIV   = FRAME_DIV_DEFAULT,
    parameter int unsigned JUMP_HEIGHT = JUMP_HEIGHT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic jump_key,
    input  logic doneP,
    input  logic doneC,
    input  logic ground,
    output logic drawB,
    output logic drawC,
    output logic enableShift,
    output logic enableX,
    output logic enableCountXC,
    output logic countUp,
    output logic countDown,
    output logic plot,
    output logic frame_overrun
);

    localparam int unsigned RISE_W = $clog2(JUMP_HEIGHT + 1);

    logic [2:0]        state;
    logic [2:0]        stateNext;
    logic [1:0]        phase;
    logic [RISE_W-1:0] riseCnt;
    logic              tick;
    logic              tickPend;
    logic              tickSeen;
    logic              keyPrev;
    logic              jumpPend;
    logic              overrun;

    frame_rate_divider #(
        .FRAME_DIV(FRAME_DIV)
    ) u_divider (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign tickSeen      = tick | tickPend;
    assign frame_overrun = overrun;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: one pass per frame tick, handshaking each sweep with the datapath
    always_comb begin
        stateNext = state;
        case (state)
            S_WAIT:   if (tickSeen) stateNext = S_SHIFT;
            S_SHIFT:  stateNext = S_BG;
            S_BG:     if (doneP) stateNext = S_BG_ACK;
            S_BG_ACK: stateNext = S_MOVE;
            S_MOVE:   stateNext = S_CH;
            S_CH:     if (doneC) stateNext = S_CH_ACK;
            S_CH_ACK: stateNext = S_WAIT;
            default:  stateNext = S_WAIT;
        endcase
    end

    // Strobe decode from the state register; character move direction follows the jump phase
    always_comb begin
        drawB         = 1'b0;
        drawC         = 1'b0;
        enableShift   = 1'b0;
        enableX       = 1'b0;
        enableCountXC = 1'b0;
        countUp       = 1'b0;
        countDown     = 1'b0;
        plot          = 1'b0;
        case (state)
            S_SHIFT: begin
                drawB       = 1'b1;
                enableShift = 1'b1;
            end
            S_BG: begin
                drawB   = 1'b1;
                enableX = 1'b1;
                plot    = 1'b1;
            end
            S_BG_ACK: drawB = 1'b1;
            S_MOVE: begin
                drawC     = 1'b1;
                countUp   = (phase == P_RISE);
                countDown = (phase == P_FALL) && !ground;
            end
            S_CH: begin
                drawC         = 1'b1;
                enableCountXC = 1'b1;
                plot          = 1'b1;
            end
            S_CH_ACK: drawC = 1'b1;
            default: ;
        endcase
    end

    // Frame ticks landing mid-pass are remembered and flagged as a sticky overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tickPend <= 1'b0;
            overrun  <= 1'b0;
        end else if (tick && (state != S_WAIT)) begin
            tickPend <= 1'b1;
            overrun  <= 1'b1;
        end else if ((state == S_WAIT) && tickSeen) begin
            tickPend <= 1'b0;
        end
    end

    // Jump request: only a fresh key press while standing on the ground counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keyPrev  <= 1'b0;
            jumpPend <= 1'b0;
        end else begin
            keyPrev <= jump_key;
            if (phase != P_GROUND) begin
                jumpPend <= 1'b0;
            end else if ((state == S_MOVE) && jumpPend) begin
                jumpPend <= 1'b0;
            end else if (jump_key && !keyPrev) begin
                jumpPend <= 1'b1;
            end
        end
    end

    // Jump phase advances once per frame, in the character move slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= P_GROUND;
            riseCnt <= '0;
        end else if (state == S_MOVE) begin
            case (phase)
                P_GROUND: begin
                    if (jumpPend) begin
                        phase   <= P_RISE;
                        riseCnt <= '0;
                    end
                end
                P_RISE: begin
                    riseCnt <= riseCnt + RISE_W'(1);
                    if (riseCnt == RISE_W'(JUMP_HEIGHT - 1)) begin
                        phase <= P_FALL;
                    end
                end
                P_FALL: begin
                    if (ground) begin
                        phase <= P_GROUND;
                    end
                end
                default: phase <= P_GROUND;
            endcase
        end
    end

endmodule
